// File: rtl/dual_pueo_beam.sv
// Two-beam PUEO power trigger: offset-binary to signed, coherent channel sum, square, sum over samples,
// compare against a double-buffered threshold. Optional macro BEAM_POWER_OUT_EN exposes the power registers.
module dual_pueo_beam #(
    parameter int unsigned NBITS = 5,
    parameter int unsigned NSAMP = 8,
    parameter int unsigned NCHAN = 8,
    localparam int unsigned SUM_W = NBITS + $clog2(NCHAN),
    localparam int unsigned SQ_W  = 2*SUM_W - 1,
    localparam int unsigned PWR_W = SQ_W + $clog2(NSAMP),
    localparam int unsigned IN_W  = NCHAN*NSAMP*NBITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IN_W-1:0]  beamA_i,
    input  logic [IN_W-1:0]  beamB_i,
    input  logic [17:0]      thresh_i,
    input  logic [1:0]       thresh_ce_i,
    input  logic             update_i,
`ifdef BEAM_POWER_OUT_EN
    output logic [1:0]       trigger_o,
    output logic [2*PWR_W-1:0] power_o
`else
    output logic [1:0]       trigger_o
`endif
);

    localparam int unsigned TH_W  = 18;
    localparam int unsigned CMP_W = (PWR_W > TH_W) ? PWR_W : TH_W;

    logic [IN_W-1:0] w_beam [2];
    assign w_beam[0] = beamA_i;
    assign w_beam[1] = beamB_i;

    for (genvar b = 0; b < 2; b++) begin : g_beam
        logic [TH_W-1:0]         r_shadow;
        logic [TH_W-1:0]         r_active;
        logic [NBITS-1:0]        w_code;
        logic signed [SUM_W-1:0] w_sum [NSAMP];
        logic signed [SUM_W-1:0] r_sum [NSAMP];
        logic [SUM_W-1:0]        w_mag [NSAMP];
        logic [SQ_W-1:0]         r_sq  [NSAMP];
        logic [PWR_W-1:0]        w_pwr;
        logic [PWR_W-1:0]        r_pwr;
        logic                    r_trig;

        // Inverting the MSB of an offset-binary code yields its two's-complement value.
        always_comb begin
            w_code = '0;
            for (int unsigned s = 0; s < NSAMP; s++) begin
                w_sum[s] = '0;
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    w_code   = w_beam[b][NBITS*NSAMP*c + NBITS*s +: NBITS];
                    w_sum[s] = w_sum[s] + $signed({{(SUM_W-NBITS+1){~w_code[NBITS-1]}},
                                                   w_code[NBITS-2:0]});
                end
            end
        end

        // Squaring the magnitude keeps the multiplier unsigned; -128 maps to 0x80 = 128.
        always_comb begin
            for (int unsigned s = 0; s < NSAMP; s++) begin
                w_mag[s] = r_sum[s][SUM_W-1] ? $unsigned(-r_sum[s]) : $unsigned(r_sum[s]);
            end
        end

        always_comb begin
            w_pwr = '0;
            for (int unsigned s = 0; s < NSAMP; s++) begin
                w_pwr = w_pwr + PWR_W'(r_sq[s]);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned s = 0; s < NSAMP; s++) begin
                    r_sum[s] <= '0;
                    r_sq[s]  <= '0;
                end
                r_pwr  <= '0;
                r_trig <= 1'b0;
            end else begin
                for (int unsigned s = 0; s < NSAMP; s++) begin
                    r_sum[s] <= w_sum[s];
                    r_sq[s]  <= SQ_W'(w_mag[s]) * SQ_W'(w_mag[s]);
                end
                r_pwr  <= w_pwr;
                r_trig <= CMP_W'(r_pwr) > CMP_W'(r_active);
            end
        end

        // Active takes the shadow value held before this edge, so load-then-update needs two clocks.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_shadow <= '1;
                r_active <= '1;
            end else begin
                if (thresh_ce_i[b]) r_shadow <= thresh_i;
                if (update_i)       r_active <= r_shadow;
            end
        end

        assign trigger_o[b] = r_trig;
`ifdef BEAM_POWER_OUT_EN
        assign power_o[b*PWR_W +: PWR_W] = r_pwr;
`endif
    end

endmodule

// File: tb/tb_dual_pueo_beam.sv
// Scoreboard bench for dual_pueo_beam: driver pushes expected triggers from a sample-level power model,
// an independent monitor pops and compares each clock.
module tb_dual_pueo_beam;
    localparam int NB = 5;
    localparam int NS = 8;
    localparam int NC = 8;
    localparam int IW = NC*NS*NB;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [IW-1:0] beamA_i = '0;
    logic [IW-1:0] beamB_i = '0;
    logic [17:0]   thresh_i = '0;
    logic [1:0]    thresh_ce_i = '0;
    logic          update_i = 1'b0;
    logic [1:0]    trigger_o;
`ifdef BEAM_POWER_OUT_EN
    logic [35:0]   power_o;
`endif

    dual_pueo_beam #(.NBITS(NB), .NSAMP(NS), .NCHAN(NC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .beamA_i     (beamA_i),
        .beamB_i     (beamB_i),
        .thresh_i    (thresh_i),
        .thresh_ce_i (thresh_ce_i),
        .update_i    (update_i),
`ifdef BEAM_POWER_OUT_EN
        .power_o     (power_o),
`endif
        .trigger_o   (trigger_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb_q[$];
    int pwr_a_q[$];
    int pwr_b_q[$];
    int shadow[2];
    int active[2];

    function automatic int beam_power(input logic [IW-1:0] v);
        int p;
        int acc;
        p = 0;
        for (int s = 0; s < NS; s++) begin
            acc = 0;
            for (int c = 0; c < NC; c++) acc += int'(v[NB*NS*c + NB*s +: NB]) - 16;
            p += acc * acc;
        end
        return p;
    endfunction

    function automatic logic [IW-1:0] pat(input int code_s[NS]);
        logic [IW-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++) v[NB*NS*c + NB*s +: NB] = NB'(code_s[s]);
        return v;
    endfunction

    function automatic logic [IW-1:0] flat(input int code);
        int cs[NS];
        for (int s = 0; s < NS; s++) cs[s] = code;
        return pat(cs);
    endfunction

    function automatic logic [IW-1:0] rnd_beam();
        logic [IW-1:0] v;
        int cs[NS];
        int mode;
        v = '0;
        mode = $urandom_range(0, 2);
        if (mode == 1) begin
            for (int s = 0; s < NS; s++) cs[s] = $urandom_range(0, 31);
            v = pat(cs);
        end else begin
            for (int i = 0; i < NC*NS; i++)
                v[NB*i +: NB] = (mode == 0) ? NB'($urandom_range(0, 31)) : NB'($urandom_range(13, 19));
        end
        return v;
    endfunction

    task automatic model_reset();
        pwr_a_q = '{0, 0, 0};
        pwr_b_q = '{0, 0, 0};
        shadow  = '{32'h3FFFF, 32'h3FFFF};
        active  = '{32'h3FFFF, 32'h3FFFF};
        sb_q.delete();
    endtask

    task automatic cycle(input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input logic [17:0] th, input logic [1:0] ce, input logic up);
        int pa, pb;
        @(negedge clk_i);
        beamA_i = a; beamB_i = b; thresh_i = th; thresh_ce_i = ce; update_i = up;
        @(posedge clk_i);
        pa = pwr_a_q.pop_front();
        pb = pwr_b_q.pop_front();
        sb_q.push_back({pb > active[1], pa > active[0]});
        if (up) active = shadow;
        if (ce[0]) shadow[0] = int'(th);
        if (ce[1]) shadow[1] = int'(th);
        pwr_a_q.push_back(beam_power(a));
        pwr_b_q.push_back(beam_power(b));
    endtask

    task automatic check_now(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: trigger_o=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (trigger_o !== e) begin
                    errors++;
                    $display("FAIL sb_trigger: trigger_o=%b expected %b at %0t", trigger_o, e, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : driver
        int lo15[NS];
        int hi15[NS];
        int s7[NS];
        lo15 = '{15, 15, 15, 15, 16, 16, 16, 16};
        hi15 = '{16, 16, 16, 16, 15, 15, 15, 15};
        s7   = '{16, 16, 16, 16, 16, 16, 16, 17};

        model_reset();
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        check_now("reset_state", trigger_o, 2'b00);

        repeat (8) cycle(flat(0), flat(0), '0, 2'b00, 1'b0);
        cycle(flat(0), flat(0), 18'd256, 2'b01, 1'b0);
        cycle(flat(0), flat(0), 18'd255, 2'b10, 1'b0);
        cycle(flat(0), flat(0), '0, 2'b00, 1'b1);
        repeat (6) cycle(flat(0), flat(0), '0, 2'b00, 1'b0);
        repeat (5) cycle(pat(lo15), pat(hi15), '0, 2'b00, 1'b0);
        repeat (5) cycle(flat(31), flat(31), '0, 2'b00, 1'b0);
        repeat (5) cycle(pat(s7), pat(s7), '0, 2'b00, 1'b0);
        repeat (5) cycle(flat(0), flat(16), '0, 2'b00, 1'b0);
        repeat (5) cycle(flat(0), flat(16), 18'd0, 2'b11, 1'b0);
        cycle(flat(0), flat(16), '0, 2'b00, 1'b1);
        repeat (5) cycle(flat(0), flat(16), '0, 2'b00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            cycle(rnd_beam(), rnd_beam(),
                  18'($urandom_range(0, 20000)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 4) == 0));
        end

        cycle(flat(0), flat(0), 18'd0, 2'b11, 1'b0);
        cycle(flat(0), flat(0), '0, 2'b00, 1'b1);
        repeat (6) cycle(flat(0), flat(0), '0, 2'b00, 1'b0);
        check_now("pre_reset_high", trigger_o, 2'b11);

        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        model_reset();
        #1 check_now("async_reset", trigger_o, 2'b00);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (8) cycle(flat(0), flat(0), '0, 2'b00, 1'b0);
        check_now("thresh_reverted", trigger_o, 2'b00);

        repeat (2) @(posedge clk_i);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
